mac_shift_reg: RTL and testbench
================================

// Module: mac_shift_reg
// PURPOSE
//   Parametrised multi-mode register for the multiplier-accumulator datapath.
//   Generalises the 1-bit load register to WIDTH bits and adds:
//     sync clear, parallel load, shift-right/left with serial I/O, shift counter.
//   Holds the multiplier/partial-product operands in the shift-add MAC.
//   The counter flags when WIDTH shifts have completed, ending an iteration.
// PARAMETERS
//   WIDTH      8      data width in bits (>=2)
//   RESET_VAL  0      value loaded into q on init0 and on clr
//   CNT_W      $clog2(WIDTH+1)  shift-counter width (derived; do not override)
// PORTS
//   clk    in   1      rising-edge clock
//   init0  in   1      async reset, active-low
//   clr    in   1      sync clear: q<=RESET_VAL, cnt<=0
//   ld     in   1      sync parallel load: q<=d, cnt<=0
//   d      in   WIDTH  parallel load data
//   sh_r   in   1      shift right one bit: q<={sin,q[WIDTH-1:1]}
//   sh_l   in   1      shift left one bit:  q<={q[WIDTH-2:0],sin}
//   sin    in   1      serial input bit for either shift
//   q      out  WIDTH  register contents
//   sout   out  1      bit shifted out: q[0] when sh_r, q[WIDTH-1] otherwise
//   cnt    out  CNT_W  shifts performed since last clr/ld/reset
//   done   out  1      cnt==WIDTH
// BEHAVIOUR
//   Reset: one clock, init0 low asynchronous and active-low.
//     q=RESET_VAL, cnt=0, done=0 immediately, independent of clk.
//     Release is sampled at the next rising clk edge.
//   Per rising edge, priority clr > ld > shift > hold:
//     clr=1         -> q<=RESET_VAL, cnt<=0 (ld/shift ignored)
//     ld=1          -> q<=d, cnt<=0 (shifts ignored)
//     sh_r^sh_l     -> shift as above, cnt<=cnt+1 unless cnt==WIDTH
//     sh_r&sh_l     -> illegal: hold q and cnt (no shift, no count)
//     none          -> hold q and cnt
//   Latency: q, cnt updated 1 clk after the control is sampled.
//   sout is combinational from q and sh_r: it is valid before the shifting edge.
//   Counter saturates at WIDTH.
//     Shifts after saturation still move q; cnt stays at WIDTH.
//   done is combinational from cnt and is high from the edge the WIDTH-th shift
//     lands until the next clr/ld/init0.
//   Unused control combinations never corrupt q.
//   Reset mid-shift sequence: q and cnt return to reset values at once.
// TESTING (WIDTH=8, RESET_VAL=0)
//   init0=0 mid-cycle with q=8'hA5 -> q=8'h00, cnt=0, done=0 before next edge
//   ld=1, d=8'h96 -> next edge q=8'h96, cnt=0.
//     Then ld=1 & sh_r=1 -> q reloads d, no shift.
//   q=8'h96, sh_r=1, sin=1 x8 -> sout seq 0,1,1,0,1,0,0,1.
//     Final q=8'hFF, cnt=8, done=1 on 8th edge.
//   q=8'h81, sh_l=1, sin=0 x1 -> q=8'h02, sout=1 before edge, cnt=1.
//     Then 10 more sh_l -> cnt stays 8.
//   sh_r=1 & sh_l=1 with q=8'h3C, cnt=3 -> q=8'h3C, cnt=3 unchanged.
//   cnt=8, clr=1 with ld=1, d=8'hFF -> q=8'h00, cnt=0, done=0 (clr wins)

Source files
------------

// File: rtl/mac_shift_reg_if.sv
// Control and data bundle for the multiplier-accumulator shift register.
// The master side drives the controls and load data; the slave side is the
// register itself, which returns its contents, serial output and shift count.
interface mac_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             sh_r;
    logic             sh_l;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output clr, ld, d, sh_r, sh_l, sin,
        input  q, sout, cnt, done
    );

    modport slave (
        input  clr, ld, d, sh_r, sh_l, sin,
        output q, sout, cnt, done
    );
endinterface

// File: rtl/mac_shift_reg.sv
// Multi-mode WIDTH-bit register for the shift-add MAC datapath.
// Supports synchronous clear, parallel load, one-bit right/left shifts with
// serial in/out, and a saturating shift counter whose terminal value (WIDTH)
// marks the end of one multiply iteration.
// Priority per edge: clr > ld > single shift > hold. Asserting both shift
// controls together is treated as illegal and simply holds q and cnt.
module mac_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                init0,
    mac_shift_reg_if.slave      bus
);
    // Counter must reach WIDTH, so it needs one more code than WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_shift_one;
    logic             w_at_max;

    // Right shift moves sin into the MSB, left shift moves it into the LSB.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign w_shr[gi] = r_q[gi+1];
            assign w_shl[gi] = bus.sin;
        end else if (gi == WIDTH - 1) begin : g_msb
            assign w_shr[gi] = bus.sin;
            assign w_shl[gi] = r_q[gi-1];
        end else begin : g_mid
            assign w_shr[gi] = r_q[gi+1];
            assign w_shl[gi] = r_q[gi-1];
        end
    end

    // Exactly one shift direction requested; both together is a no-op.
    assign w_shift_one = bus.sh_r ^ bus.sh_l;
    assign w_at_max    = (r_cnt == CNT_MAX);

    // Next-state selection in priority order clr > ld > shift > hold.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = r_cnt;
        if (bus.clr) begin
            w_q_next   = RESET_VAL;
            w_cnt_next = '0;
        end else if (bus.ld) begin
            w_q_next   = bus.d;
            w_cnt_next = '0;
        end else if (w_shift_one) begin
            w_q_next = bus.sh_r ? w_shr : w_shl;
            if (!w_at_max) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // State register with asynchronous active-low initialisation.
    always_ff @(posedge clk or negedge init0) begin
        if (!init0) begin
            r_q   <= RESET_VAL;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign bus.q    = r_q;
    assign bus.cnt  = r_cnt;
    assign bus.done = w_at_max;
    // Bit that would leave the register on this edge, visible ahead of it.
    assign bus.sout = bus.sh_r ? r_q[0] : r_q[WIDTH-1];
endmodule

// File: tb/tb_mac_shift_reg.sv
// Bench for mac_shift_reg (WIDTH=8, RESET_VAL=0): directed vector table,
// hand-written asynchronous reset sequences, then random traffic against a
// plain arithmetic reference model.
module tb_mac_shift_reg;
    localparam int WIDTH = 8;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] d;
        logic       sh_r;
        logic       sh_l;
        logic       sin;
        logic       exp_sout;
        logic [7:0] exp_q;
        int         exp_cnt;
    } vec_t;

    logic clk;
    logic init0;
    int   errors;
    int   checks;
    vec_t vecs[$];

    // Reference model state
    int m_q;
    int m_cnt;

    mac_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    mac_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .init0 (init0),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic clr, input logic ld, input logic [7:0] d,
                       input logic sh_r, input logic sh_l, input logic sin,
                       input logic exp_sout, input logic [7:0] exp_q, input int exp_cnt);
        vec_t v;
        v.clr = clr; v.ld = ld; v.d = d; v.sh_r = sh_r; v.sh_l = sh_l; v.sin = sin;
        v.exp_sout = exp_sout; v.exp_q = exp_q; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    // Drive one control set, check sout before the edge and state after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.clr = v.clr; bus.ld = v.ld; bus.d = v.d;
        bus.sh_r = v.sh_r; bus.sh_l = v.sh_l; bus.sin = v.sin;
        #1;
        check({tag, ".sout"}, int'(bus.sout), int'(v.exp_sout));
        @(posedge clk);
        #1;
        check({tag, ".q"}, int'(bus.q), int'(v.exp_q));
        check({tag, ".cnt"}, int'(bus.cnt), v.exp_cnt);
        check({tag, ".done"}, int'(bus.done), (v.exp_cnt == WIDTH) ? 1 : 0);
        $display("%s clr=%0b ld=%0b d=%02h shr=%0b shl=%0b sin=%0b -> q=%02h cnt=%0d done=%0b",
                 tag, v.clr, v.ld, v.d, v.sh_r, v.sh_l, v.sin, bus.q, bus.cnt, bus.done);
    endtask

    task automatic idle();
        bus.clr = 0; bus.ld = 0; bus.d = '0; bus.sh_r = 0; bus.sh_l = 0; bus.sin = 0;
    endtask

    // Reference: arithmetic view of the register rules.
    task automatic model_step(inout vec_t v);
        v.exp_sout = v.sh_r ? logic'(m_q % 2) : logic'(m_q / 128);
        if (v.clr) begin
            m_q = 0; m_cnt = 0;
        end else if (v.ld) begin
            m_q = int'(v.d); m_cnt = 0;
        end else if (v.sh_r != v.sh_l) begin
            if (v.sh_r) m_q = m_q / 2 + (v.sin ? 128 : 0);
            else        m_q = (m_q * 2 + (v.sin ? 1 : 0)) % 256;
            if (m_cnt < WIDTH) m_cnt = m_cnt + 1;
        end
        v.exp_q   = 8'(m_q);
        v.exp_cnt = m_cnt;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        init0  = 1'b0;
        idle();

        // Directed table
        add(0, 1, 8'h96, 0, 0, 0, 0, 8'h96, 0);   // load
        add(0, 1, 8'h96, 1, 0, 1, 0, 8'h96, 0);   // ld beats sh_r
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'hCB, 1);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'hE5, 2);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'hF2, 3);
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'hF9, 4);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'hFC, 5);
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'hFE, 6);
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'hFF, 7);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'hFF, 8);   // done
        add(0, 1, 8'h78, 0, 0, 0, 1, 8'h78, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h78, 2);
        add(0, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 3);
        add(0, 0, 8'h00, 1, 1, 1, 0, 8'h3C, 3);   // illegal: hold
        add(0, 0, 8'h00, 0, 0, 1, 0, 8'h3C, 3);   // idle hold
        add(0, 1, 8'h81, 0, 0, 0, 0, 8'h81, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 8'h02, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h04, 2);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h08, 3);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h10, 4);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h20, 5);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h40, 6);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h80, 7);
        add(0, 0, 8'h00, 0, 1, 0, 1, 8'h00, 8);
        add(0, 0, 8'h00, 0, 1, 1, 0, 8'h01, 8);   // saturated, q still moves
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h02, 8);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h04, 8);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 0);   // clr=1 set below
        vecs[vecs.size()-1].clr = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset.q", int'(bus.q), 0);
        check("reset.cnt", int'(bus.cnt), 0);
        check("reset.done", int'(bus.done), 0);
        @(negedge clk);
        init0 = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle with q=A5
        begin
            vec_t v;
            v.clr = 0; v.ld = 1; v.d = 8'hA5; v.sh_r = 0; v.sh_l = 0; v.sin = 0;
            v.exp_sout = 0; v.exp_q = 8'hA5; v.exp_cnt = 0;
            apply(v, "pre_rst");
        end
        idle();
        @(posedge clk);
        #3;
        init0 = 1'b0;
        #1;
        check("arst.q", int'(bus.q), 0);
        check("arst.cnt", int'(bus.cnt), 0);
        check("arst.done", int'(bus.done), 0);
        $display("async reset mid-cycle -> q=%02h cnt=%0d done=%0b", bus.q, bus.cnt, bus.done);
        @(negedge clk);
        init0 = 1'b1;

        // Reset in the middle of a shift sequence
        m_q = 8'h96; m_cnt = 0;
        begin
            vec_t v;
            v.clr = 0; v.ld = 1; v.d = 8'h96; v.sh_r = 0; v.sh_l = 0; v.sin = 0;
            v.exp_sout = 0; v.exp_q = 8'h96; v.exp_cnt = 0;
            apply(v, "mid_ld");
            for (int k = 0; k < 3; k++) begin
                v.ld = 0; v.sh_r = 1; v.sin = 1;
                model_step(v);
                apply(v, $sformatf("mid_sh%0d", k));
            end
        end
        @(posedge clk);
        #2;
        init0 = 1'b0;
        #1;
        check("mid_rst.q", int'(bus.q), 0);
        check("mid_rst.cnt", int'(bus.cnt), 0);
        $display("reset mid-shift -> q=%02h cnt=%0d", bus.q, bus.cnt);
        @(negedge clk);
        idle();
        init0 = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.q", int'(bus.q), 0);
        check("post_rst.cnt", int'(bus.cnt), 0);

        // Randomised traffic against the reference model
        m_q = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.clr  = ($urandom_range(0, 24) == 0);
            v.ld   = ($urandom_range(0, 9) == 0);
            v.d    = 8'($urandom_range(0, 255));
            v.sh_r = 1'($urandom_range(0, 1));
            v.sh_l = ($urandom_range(0, 2) == 0);
            v.sin  = 1'($urandom_range(0, 1));
            model_step(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
